// File: rtl/multi_cycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl_pkg
// Purpose  : Shared definitions for the multi-cycle controller.
//            Contents:
//              - state encoding (state_t)
//              - opcode constants
//              - ALU-op constants
//              - control-vector struct (ctrl_t)
//            The JUMP state exists only when MULTI_CYCLE_CTRL_JUMP_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
package multi_cycle_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_MEM   = 4'd7,
        WB_ALU   = 4'd8,
        BRANCH   = 4'd9,
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
        JUMP     = 4'd10,
`endif
        ILLEGAL  = 4'd11
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_slti  = 6'b001010;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;

    localparam int unsigned c_alu_add   = 0;
    localparam int unsigned c_alu_sub   = 1;
    localparam int unsigned c_alu_rtype = 2;
    localparam int unsigned c_alu_slt   = 3;

    typedef struct packed {
        logic reg_write;
        logic alu_src_2;
        logic reg_dst;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic pc_write;
        logic ir_write;
        logic jump;
        logic illegal;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/multi_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl_if
// Purpose  : Bundle of the controller's instruction/memory inputs and its
//            control outputs.
//            Modports:
//              - master : the datapath side; drives instr_op_i, mem_ready_i
//              - slave  : the controller side; drives the control outputs
//                         and state_o
// Revision : 1.0 - initial release
// ============================================================================
interface multi_cycle_ctrl_if #(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 3
);
    logic [OP_W-1:0]     instr_op_i;
    logic                mem_ready_i;
    logic                RegWrite_o;
    logic                ALUSrc_2_o;
    logic                RegDst_o;
    logic                Branch_o;
    logic                MemRead_o;
    logic                MemWrite_o;
    logic                MemtoReg_o;
    logic                PCWrite_o;
    logic                IRWrite_o;
    logic                Jump_o;
    logic                illegal_o;
    logic [ALU_OP_W-1:0] ALU_op_o;
    logic [3:0]          state_o;

    modport master (
        output instr_op_i, mem_ready_i,
        input  RegWrite_o, ALUSrc_2_o, RegDst_o, Branch_o, MemRead_o,
               MemWrite_o, MemtoReg_o, PCWrite_o, IRWrite_o, Jump_o,
               illegal_o, ALU_op_o, state_o
    );

    modport slave (
        input  instr_op_i, mem_ready_i,
        output RegWrite_o, ALUSrc_2_o, RegDst_o, Branch_o, MemRead_o,
               MemWrite_o, MemtoReg_o, PCWrite_o, IRWrite_o, Jump_o,
               illegal_o, ALU_op_o, state_o
    );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_ctrl_ctrl_out_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_out_decode
// Purpose  : Combinational decode of current state (plus latched opcode and
//            the memory handshake) into the control vector and ALU-op code.
// Ports    : state     in   current FSM state
//            op        in   opcode latched in DECODE
//            mem_ready in   memory handshake (qualifies FETCH IR/PC write)
//            ctrl      out  control flags
//            alu_op    out  ALU-op code (ADD unless a state names another)
// Config   : MULTI_CYCLE_CTRL_JUMP_EN enables the JUMP state decode.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_out_decode
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 3
) (
    input  state_t              state,
    input  logic [OP_W-1:0]     op,
    input  logic                mem_ready,
    output ctrl_t               ctrl,
    output logic [ALU_OP_W-1:0] alu_op
);

    always_comb begin
        ctrl   = '0;
        alu_op = ALU_OP_W'(c_alu_add);
        case (state)
            FETCH: begin
                ctrl.mem_read = 1'b1;
                // Instruction is captured only in the cycle memory answers.
                ctrl.ir_write = mem_ready;
                ctrl.pc_write = mem_ready;
            end
            EXEC_R: begin
                alu_op = ALU_OP_W'(c_alu_rtype);
            end
            EXEC_I: begin
                ctrl.alu_src_2 = 1'b1;
                alu_op = (op == OP_W'(c_op_slti)) ? ALU_OP_W'(c_alu_slt)
                                                  : ALU_OP_W'(c_alu_add);
            end
            WB_ALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = (op == OP_W'(c_op_rtype));
            end
            MEM_ADDR: begin
                ctrl.alu_src_2 = 1'b1;
            end
            MEM_RD: begin
                ctrl.mem_read = 1'b1;
            end
            MEM_WR: begin
                ctrl.mem_write = 1'b1;
            end
            WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            BRANCH: begin
                ctrl.branch = 1'b1;
                alu_op      = ALU_OP_W'(c_alu_sub);
            end
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
            JUMP: begin
                ctrl.jump     = 1'b1;
                ctrl.pc_write = 1'b1;
            end
`endif
            ILLEGAL: begin
                ctrl.illegal = 1'b1;
            end
            default: begin
                ctrl   = '0;
                alu_op = ALU_OP_W'(c_alu_add);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl
// Purpose  : Multi-cycle processor control FSM. Holds the state register and
//            the opcode latched in DECODE; control outputs are decoded from
//            state by ctrl_out_decode.
// Ports    : clk_i  in  clock, rising edge
//            rst_i  in  asynchronous active-low reset
//            bus    slave modport of multi_cycle_ctrl_if (opcode, memory
//                   handshake, control outputs, state_o)
// Config   : MULTI_CYCLE_CTRL_JUMP_EN - opcode 000010 takes the JUMP path;
//            when undefined it is treated as illegal and Jump_o is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    multi_cycle_ctrl_if.slave   bus
);

    state_t              r_state;
    logic [OP_W-1:0]     r_op;
    ctrl_t               w_dec;
    logic [ALU_OP_W-1:0] w_alu;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= FETCH;
            r_op    <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (bus.mem_ready_i) r_state <= DECODE;
                end
                DECODE: begin
                    // Later states look only at r_op, so the IR input may
                    // change freely once DECODE has passed.
                    r_op <= bus.instr_op_i;
                    if (bus.instr_op_i == OP_W'(c_op_rtype))
                        r_state <= EXEC_R;
                    else if (bus.instr_op_i == OP_W'(c_op_addi) ||
                             bus.instr_op_i == OP_W'(c_op_slti))
                        r_state <= EXEC_I;
                    else if (bus.instr_op_i == OP_W'(c_op_lw) ||
                             bus.instr_op_i == OP_W'(c_op_sw))
                        r_state <= MEM_ADDR;
                    else if (bus.instr_op_i == OP_W'(c_op_beq))
                        r_state <= BRANCH;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
                    else if (bus.instr_op_i == OP_W'(c_op_j))
                        r_state <= JUMP;
`endif
                    else
                        r_state <= ILLEGAL;
                end
                EXEC_R, EXEC_I: r_state <= WB_ALU;
                MEM_ADDR: begin
                    r_state <= (r_op == OP_W'(c_op_lw)) ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    if (bus.mem_ready_i) r_state <= WB_MEM;
                end
                MEM_WR: begin
                    if (bus.mem_ready_i) r_state <= FETCH;
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    ctrl_out_decode #(
        .OP_W     (OP_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_ctrl_out_decode (
        .state     (r_state),
        .op        (r_op),
        .mem_ready (bus.mem_ready_i),
        .ctrl      (w_dec),
        .alu_op    (w_alu)
    );

    // Outputs are gated by reset so that asserting rst_i silences every
    // control line at once, even though FETCH itself drives MemRead.
    assign bus.RegWrite_o = rst_i & w_dec.reg_write;
    assign bus.ALUSrc_2_o = rst_i & w_dec.alu_src_2;
    assign bus.RegDst_o   = rst_i & w_dec.reg_dst;
    assign bus.Branch_o   = rst_i & w_dec.branch;
    assign bus.MemRead_o  = rst_i & w_dec.mem_read;
    assign bus.MemWrite_o = rst_i & w_dec.mem_write;
    assign bus.MemtoReg_o = rst_i & w_dec.mem_to_reg;
    assign bus.PCWrite_o  = rst_i & w_dec.pc_write;
    assign bus.IRWrite_o  = rst_i & w_dec.ir_write;
    assign bus.illegal_o  = rst_i & w_dec.illegal;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
    assign bus.Jump_o     = rst_i & w_dec.jump;
`else
    assign bus.Jump_o     = 1'b0;
`endif
    assign bus.ALU_op_o   = rst_i ? w_alu : '0;
    assign bus.state_o    = r_state;

endmodule
`default_nettype wire
